cmt_uart_rx: RTL and testbench

CMT_UART_RX -- requirements
Module: cmt_uart_rx

---
 rtl/cmt_pkg.sv | 20 ++
 rtl/cmt_rx_fifo.sv | 47 ++++
 rtl/cmt_uart_rx.sv | 175 +++++++++++++++++
 tb/tb_cmt_uart_rx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmt_pkg.sv
// Shared types and constants for the CMT cassette UART receiver.
// Parity support is selected at build time with CMT_RX_PARITY_EN.
package cmt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int OVS_DIV_DEF    = 5208;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int TICKS_PER_BIT  = 16;
    localparam int TCNT_W         = $clog2(TICKS_PER_BIT);
    localparam int DATA_BITS      = 8;
    localparam int BIT_W          = $clog2(DATA_BITS);

endpackage

// File: rtl/cmt_rx_fifo.sv
// First-word-fall-through receive FIFO; pointers carry one extra wrap bit
// so equal indices can be told apart as full or empty.
module cmt_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_ONE;
            if (do_pop)  rd_q <= rd_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cmt_uart_rx.sv
// CMT cassette UART receiver: 16x oversampled framing FSM feeding a small FIFO.
// Define CMT_RX_PARITY_EN to expect an even-parity bit after the data bits.
module cmt_uart_rx
    import cmt_pkg::*;
#(
    parameter int OVS_DIV    = OVS_DIV_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    input  logic       rd_pop,
    input  logic       clr_err,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       framing_err,
    output logic       overrun_err,
    output logic       parity_err
);

    localparam int DIV_W = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(OVS_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE    = DIV_W'(1);
    localparam logic [TCNT_W-1:0] TCNT_ONE   = TCNT_W'(1);
    localparam logic [TCNT_W-1:0] BIT_LAST   = TCNT_W'(TICKS_PER_BIT - 1);
    localparam logic [TCNT_W-1:0] START_LAST = TCNT_W'(TICKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE    = BIT_W'(1);
    localparam logic [BIT_W-1:0]  BIT_MAX    = BIT_W'(DATA_BITS - 1);

    logic                 rx_s1_q, rx_s2_q;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 tick;
    rx_state_e            state_q;
    logic [TCNT_W-1:0]    tcnt_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_bad_q;
    logic                 push_q;
    logic                 framing_q, overrun_q, parity_q;
    logic                 bit_end;
    logic                 framing_set, overrun_set, parity_set;
    logic                 fifo_full, fifo_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rxd;
            rx_s2_q <= rx_s1_q;
        end
    end

    assign tick  = (div_q == DIV_LAST);
    assign div_d = tick ? '0 : div_q + DIV_ONE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) div_q <= '0;
        else          div_q <= div_d;
    end

    assign bit_end = tick && (tcnt_q == BIT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            tcnt_q    <= '0;
            bit_q     <= '0;
            par_bad_q <= 1'b0;
            push_q    <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (tick) begin
                case (state_q)
                    IDLE: begin
                        if (!rx_s2_q) begin
                            state_q <= START;
                            tcnt_q  <= '0;
                        end
                    end
                    START: begin
                        // Half a bit after the edge: a high line here was only a glitch.
                        if (tcnt_q == START_LAST) begin
                            tcnt_q    <= '0;
                            bit_q     <= '0;
                            par_bad_q <= 1'b0;
                            state_q   <= rx_s2_q ? IDLE : DATA;
                        end else begin
                            tcnt_q <= tcnt_q + TCNT_ONE;
                        end
                    end
                    DATA: begin
                        if (tcnt_q == BIT_LAST) begin
                            tcnt_q <= '0;
                            bit_q  <= bit_q + BIT_ONE;
                            if (bit_q == BIT_MAX) begin
`ifdef CMT_RX_PARITY_EN
                                state_q <= PARITY;
`else
                                state_q <= STOP;
`endif
                            end
                        end else begin
                            tcnt_q <= tcnt_q + TCNT_ONE;
                        end
                    end
                    PARITY: begin
                        if (tcnt_q == BIT_LAST) begin
                            tcnt_q    <= '0;
                            par_bad_q <= (rx_s2_q != ^shift_q);
                            state_q   <= STOP;
                        end else begin
                            tcnt_q <= tcnt_q + TCNT_ONE;
                        end
                    end
                    STOP: begin
                        if (tcnt_q == BIT_LAST) begin
                            tcnt_q  <= '0;
                            push_q  <= rx_s2_q && !par_bad_q;
                            state_q <= IDLE;
                        end else begin
                            tcnt_q <= tcnt_q + TCNT_ONE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Shift register holds payload only; the FSM decides when it is meaningful.
    always_ff @(posedge clk) begin
        if (bit_end && (state_q == DATA)) shift_q <= {rx_s2_q, shift_q[DATA_BITS-1:1]};
    end

    assign framing_set = bit_end && (state_q == STOP) && !rx_s2_q;
    assign overrun_set = push_q && fifo_full && !rd_pop;
`ifdef CMT_RX_PARITY_EN
    assign parity_set  = bit_end && (state_q == PARITY) && (rx_s2_q != ^shift_q);
`else
    assign parity_set  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            framing_q <= 1'b0;
            overrun_q <= 1'b0;
            parity_q  <= 1'b0;
        end else begin
            framing_q <= framing_set || (framing_q && !clr_err);
            overrun_q <= overrun_set || (overrun_q && !clr_err);
            parity_q  <= parity_set  || (parity_q  && !clr_err);
        end
    end

    cmt_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_q),
        .pop     (rd_pop),
        .din     (shift_q),
        .dout    (data_out),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign data_valid  = !fifo_empty;
    assign framing_err = framing_q;
    assign overrun_err = overrun_q;
    assign parity_err  = parity_q;

endmodule

// File: tb/tb_cmt_uart_rx.sv
// Scoreboard bench for cmt_uart_rx at OVS_DIV = 4; parity cases build with CMT_RX_PARITY_EN.
module tb_cmt_uart_rx;

    localparam int OVS      = 4;
    localparam int DEPTH    = 4;
    localparam int BIT_CLKS = 16 * OVS;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rxd = 1'b1;
    logic       rd_pop = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_err;
    logic       overrun_err;
    logic       parity_err;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    bit         lat_pend = 1'b0;
`ifdef CMT_RX_PARITY_EN
    logic       par_flip_g = 1'b0;
`endif

    cmt_uart_rx #(
        .OVS_DIV    (OVS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rxd         (rxd),
        .rd_pop      (rd_pop),
        .clr_err     (clr_err),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .framing_err (framing_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every byte leaving the FIFO and the push-to-valid latency.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset_n) begin
                if (lat_pend) begin
                    check("push_to_valid_latency", {31'd0, data_valid}, 32'd1);
                    lat_pend = 1'b0;
                end
                if (dut.push_q && !data_valid) lat_pend = 1'b1;
                if (rd_pop && data_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL pop_extra: actual=0x%0h required=no byte", data_out);
                    end else begin
                        check("pop_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef CMT_RX_PARITY_EN
        drive_bit(^b ^ par_flip_g);
`endif
        drive_bit(stop_b);
        drive_bit(1'b1);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            rd_pop = 1'b1;
            @(negedge clk);
        end
        rd_pop = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_flags(input string tag, input logic f, input logic o, input logic p);
        check({tag, "_framing"}, {31'd0, framing_err}, {31'd0, f});
        check({tag, "_overrun"}, {31'd0, overrun_err}, {31'd0, o});
        check({tag, "_parity"},  {31'd0, parity_err},  {31'd0, p});
    endtask

    initial begin
        bit got;
        repeat (3) @(negedge clk);
        check("reset_valid", {31'd0, data_valid}, 32'd0);
        check("reset_data", {24'd0, data_out}, 32'd0);
        check_flags("reset", 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);

        // Clean 0xA5 frame.
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        check("a5_valid", {31'd0, data_valid}, 32'd1);
        check("a5_head", {24'd0, data_out}, 32'h0000_00A5);
        check_flags("a5", 1'b0, 1'b0, 1'b0);
        pop_n(1);
        check("a5_empty", {31'd0, data_valid}, 32'd0);

        // Four-tick low glitch must be rejected silently.
        rxd = 1'b0;
        repeat (4 * OVS) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * BIT_CLKS) @(negedge clk);
        check("glitch_valid", {31'd0, data_valid}, 32'd0);
        check_flags("glitch", 1'b0, 1'b0, 1'b0);

        // 0x3C with a low stop bit.
        send_frame(8'h3C, 1'b0);
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("frm_valid", {31'd0, data_valid}, 32'd0);
        check_flags("frm", 1'b1, 1'b0, 1'b0);
        pulse_clr();
        check("frm_cleared", {31'd0, framing_err}, 32'd0);

        // Five frames into a four-entry FIFO.
        for (int i = 1; i <= 5; i++) begin
            if (i <= DEPTH) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
        end
        check_flags("ovr", 1'b0, 1'b1, 1'b0);
        check("ovr_head", {24'd0, data_out}, 32'h0000_0001);
        pop_n(DEPTH + 1);
        check("ovr_drained_valid", {31'd0, data_valid}, 32'd0);
        check("ovr_drained_data", {24'd0, data_out}, 32'd0);
        pulse_clr();
        check("ovr_cleared", {31'd0, overrun_err}, 32'd0);

        // Full FIFO, pop coincides with the push of 0x55.
        for (int i = 1; i <= DEPTH; i++) begin
            exp_q.push_back(8'(8'h11 * i));
            send_frame(8'(8'h11 * i), 1'b1);
        end
        exp_q.push_back(8'h55);
        got = 1'b0;
        fork
            send_frame(8'h55, 1'b1);
            begin
                for (int k = 0; k < 12 * BIT_CLKS && !got; k++) begin
                    @(negedge clk);
                    if (dut.push_q) begin
                        got = 1'b1;
                        rd_pop = 1'b1;
                        @(negedge clk);
                        rd_pop = 1'b0;
                    end
                end
            end
        join
        check("simul_push_seen", {31'd0, got}, 32'd1);
        check_flags("simul", 1'b0, 1'b0, 1'b0);
        pop_n(DEPTH + 2);
        check("simul_drained_valid", {31'd0, data_valid}, 32'd0);

`ifdef CMT_RX_PARITY_EN
        // 0x07 has odd weight, so its even-parity bit is 1.
        par_flip_g = 1'b1;
        send_frame(8'h07, 1'b1);
        check("par_bad_valid", {31'd0, data_valid}, 32'd0);
        check_flags("par_bad", 1'b0, 1'b0, 1'b1);
        pulse_clr();
        check("par_cleared", {31'd0, parity_err}, 32'd0);
        par_flip_g = 1'b0;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1);
        check_flags("par_good", 1'b0, 1'b0, 1'b0);
        check("par_good_valid", {31'd0, data_valid}, 32'd1);
        pop_n(1);
`else
        check("parity_tied_low", {31'd0, parity_err}, 32'd0);
`endif

        // Reset in the middle of a frame: nothing may be pushed.
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0);
        reset_n = 1'b0;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (12 * BIT_CLKS) @(negedge clk);
        check("midreset_valid", {31'd0, data_valid}, 32'd0);
        check_flags("midreset", 1'b0, 1'b0, 1'b0);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
